branch_predictor_table: RTL and testbench
=========================================

# branch_predictor_table

Parametrised branch predictor: a table of 2^IDX_W saturating counters, CTR_W bits each, indexed gshare-style by the request PC bits XORed with a global history register of HIST_W resolved outcomes. It generalises the single 2-bit counter predictor to many entries, configurable counter width, and history correlation. The result port carries back the table index issued with each prediction, so training hits the entry that produced it. It sits beside the fetch stage: fetch issues lookups, and execute returns resolved outcomes.

## Interface
- CTR_W, 2: counter width in bits, 1..8; prediction is the counter MSB.
- IDX_W, 4: table index width; the table holds 2^IDX_W entries.
- HIST_W, 4: global history length, 0..IDX_W; 0 gives a pure bimodal table.

Ports (clk, rst first):
- clk  in  1  single clock; all state changes on its posedge.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- req_valid  in  1  lookup request this cycle.
- req_pc  in  IDX_W  low PC bits of the branch.
- pred_valid  out  1  one-cycle pulse; prediction below is fresh.
- pred_taken  out  1  predicted direction; holds last value between requests.
- pred_idx  out  IDX_W  table index used; fetch returns it on res_idx.
- res_valid  in  1  resolved-branch update this cycle.
- res_idx  in  IDX_W  entry to train (a previously issued pred_idx).
- res_taken  in  1  actual outcome.

## Operation
- Lookup index: idx = req_pc XOR zero-extend(ghr), with ghr HIST_W bits wide. When HIST_W = 0, idx = req_pc.
- Training on res_valid:
  - res_taken = 1: ctr[res_idx] increments, saturating at 2^CTR_W−1.
  - res_taken = 0: ctr[res_idx] decrements, saturating at 0.
  - ghr becomes {ghr[HIST_W-2:0], res_taken}, with the newest outcome in the LSB.
- History is non-speculative: it updates only on resolution, never on prediction.
- Prediction: pred_taken = MSB of the selected counter value.
- Same-cycle req_valid and res_valid:
  - The request index uses the pre-update ghr.
  - If idx == res_idx, the prediction uses the post-update (forwarded) counter value.
  - Otherwise it uses the stored value.
- Multiple results back-to-back, including to the same index: each is applied in order, one per cycle. There is no loss and no merging.
- Reset (rst = 1) sets:
  - every counter to weakly-not-taken, 2^(CTR_W−1)−1 (for CTR_W = 1, that is 0);
  - ghr to 0;
  - pred_valid, pred_taken and pred_idx to 0.
- Reset priority: while rst = 1, req_valid and res_valid are ignored. Reset mid-stream discards any in-flight outcome, and no pred_valid pulse follows a request made during the reset cycle.
- There is no flow control. Requests and results are accepted every cycle, unconditionally.

## Timing
- Lookup latency is 1 cycle: a request at edge N gives pred_valid = 1 with data valid after edge N+1, for exactly one cycle.
- A counter update is visible to a lookup in the same cycle through forwarding, and to any later lookup from storage.
- A ghr update at edge N affects indices computed from requests at edge N+1 onward.
- pred_taken and pred_idx are registered outputs. They change only on a request edge or a reset edge.

## Structure
- Package bp_pkg holds:
  - function ctr_init(CTR_W);
  - saturating inc/dec functions;
  - the index-hash function (pc, ghr), so fetch-side models reuse it.
- Sub-module bp_counter_table holds the counter storage, the synchronous reset of all entries, the update port, and the read port with same-cycle write forwarding.
- The top level holds ghr, the index hash, and the output registers.

## Test plan
Defaults: CTR_W = 2, IDX_W = 4, HIST_W = 4.
1. Reset, then req_pc = 3 → one cycle later: pred_valid = 1, pred_idx = 3, pred_taken = 0; the following cycle pred_valid = 0 while pred_taken holds 0.
2. Train entry 5: three results (res_idx = 5, taken) → ctr[5] goes 1→2→3 and ghr goes 0001→0011→0111. Then req_pc = 2 → pred_idx = 5, pred_taken = 1.
3. Saturation on entry 5:
   - 5 more taken results → ctr stays 3.
   - 1 not-taken → 2, pred_taken = 1.
   - 2 more not-taken → 0.
   - 3 more not-taken → stays 0, pred_taken = 0.
4. Collision: after reset, same cycle res_idx = 4 taken and req_pc = 4 → pred_idx = 4 (pre-update ghr = 0), pred_taken = 1 (forwarded ctr = 2). A subsequent req_pc = 5 → pred_idx = 4 (ghr = 0001), pred_taken = 1.
5. Reset mid-stream:
   - After scenario 2, assert rst together with req_valid and res_valid → next cycle pred_valid = 0 and pred_taken = 0.
   - After release, req_pc = 5 → pred_idx = 5 (ghr = 0), pred_taken = 0.
6. Parameter sweep (CTR_W = 3, HIST_W = 0):
   - Reset → counters reset to 3 (weakly not-taken).
   - One taken result at idx 7 → ctr = 4, and req_pc = 7 → pred_taken = 1 with pred_idx = 7.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared helpers for the gshare predictor: counter init value, saturating
// counter arithmetic and the index hash that fetch-side models reuse.
package bp_pkg;

  localparam int BP_CTR_MAX_W = 8;
  localparam int BP_IDX_MAX_W = 16;

  typedef logic [BP_CTR_MAX_W-1:0] bp_ctr_t;
  typedef logic [BP_IDX_MAX_W-1:0] bp_idx_t;

  // Weakly-not-taken: the largest value whose MSB is still 0.
  function automatic bp_ctr_t ctr_init(input int ctr_w);
    return bp_ctr_t'((1 << (ctr_w - 1)) - 1);
  endfunction

  function automatic bp_ctr_t sat_inc(input bp_ctr_t v, input int ctr_w);
    bp_ctr_t max_v;
    max_v = bp_ctr_t'((1 << ctr_w) - 1);
    return (v >= max_v) ? max_v : v + bp_ctr_t'(1);
  endfunction

  function automatic bp_ctr_t sat_dec(input bp_ctr_t v);
    return (v == '0) ? v : v - bp_ctr_t'(1);
  endfunction

  function automatic bp_idx_t bp_hash(input bp_idx_t pc, input bp_idx_t ghr);
    return pc ^ ghr;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Saturating-counter storage with one update port and one read port; the read
// sees a same-cycle update to the same entry.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int CTR_W = 2,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [CTR_W-1:0] o_rd_ctr
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_init(CTR_W));

  logic [CTR_W-1:0] r_ctr [DEPTH];
  logic [CTR_W-1:0] w_wr_cur;
  logic [CTR_W-1:0] w_wr_next;

  assign w_wr_cur  = r_ctr[i_wr_idx];
  assign w_wr_next = i_wr_taken ? CTR_W'(sat_inc(bp_ctr_t'(w_wr_cur), CTR_W))
                                : CTR_W'(sat_dec(bp_ctr_t'(w_wr_cur)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_RST;
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= w_wr_next;
    end
  end

  // Forward the counter being trained this cycle so the lookup never sees stale data.
  assign o_rd_ctr = (i_wr_en && (i_wr_idx == i_rd_idx)) ? w_wr_next : r_ctr[i_rd_idx];

endmodule

// File: rtl/branch_predictor_table.sv
// gshare branch predictor: request PC XOR global history selects a saturating
// counter; resolved outcomes train the counter and shift into the history.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int CTR_W  = 2,
  parameter int IDX_W  = 4,
  parameter int HIST_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             res_valid,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_taken
);

  logic [IDX_W-1:0] w_ghr_ext;
  logic [IDX_W-1:0] w_idx;
  logic [CTR_W-1:0] w_rd_ctr;
  logic             r_pred_valid;
  logic             r_pred_taken;
  logic [IDX_W-1:0] r_pred_idx;

  // History is non-speculative: it shifts only on resolution, newest outcome in the LSB.
  if (HIST_W > 0) begin : g_hist
    logic [HIST_W-1:0] r_ghr;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_ghr <= '0;
      end else if (res_valid) begin
        r_ghr <= HIST_W'({r_ghr, res_taken});
      end
    end
    assign w_ghr_ext = IDX_W'(r_ghr);
  end else begin : g_nohist
    assign w_ghr_ext = '0;
  end

  assign w_idx = IDX_W'(bp_hash(bp_idx_t'(req_pc), bp_idx_t'(w_ghr_ext)));

  bp_counter_table #(
    .CTR_W(CTR_W),
    .IDX_W(IDX_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (res_valid),
    .i_wr_idx  (res_idx),
    .i_wr_taken(res_taken),
    .i_rd_idx  (w_idx),
    .o_rd_ctr  (w_rd_ctr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_idx   <= '0;
    end else begin
      r_pred_valid <= req_valid;
      if (req_valid) begin
        r_pred_taken <= w_rd_ctr[CTR_W-1];
        r_pred_idx   <= w_idx;
      end
    end
  end

  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_taken;
  assign pred_idx   = r_pred_idx;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Bench for branch_predictor_table: directed scenarios plus random traffic,
// two parameterisations driven in lockstep against an integer reference model.
module tb_branch_predictor_table;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_pc;
  logic       res_valid;
  logic [3:0] res_idx;
  logic       res_taken;

  logic       a_pv, a_pt, b_pv, b_pt;
  logic [3:0] a_pi, b_pi;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, one set per DUT
  int cw [2] = '{2, 3};
  int hw [2] = '{4, 0};
  int m_ctr [2][16];
  int m_ghr [2];
  int m_pv  [2];
  int m_pt  [2];
  int m_pi  [2];

  always #5 clk = ~clk;

  branch_predictor_table #(.CTR_W(2), .IDX_W(4), .HIST_W(4)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
    .pred_valid(a_pv), .pred_taken(a_pt), .pred_idx(a_pi),
    .res_valid(res_valid), .res_idx(res_idx), .res_taken(res_taken)
  );

  branch_predictor_table #(.CTR_W(3), .IDX_W(4), .HIST_W(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
    .pred_valid(b_pv), .pred_taken(b_pt), .pred_idx(b_pi),
    .res_valid(res_valid), .res_idx(res_idx), .res_taken(res_taken)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge of the specified behaviour: train first, then read, so a
  // same-cycle lookup of the trained entry sees the new count.
  task automatic model_edge();
    int idx, c, cmax;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int e = 0; e < 16; e++) m_ctr[d][e] = (1 << (cw[d] - 1)) - 1;
        m_ghr[d] = 0;
        m_pv[d] = 0; m_pt[d] = 0; m_pi[d] = 0;
      end else begin
        idx = int'(req_pc) ^ m_ghr[d];
        if (res_valid) begin
          cmax = (1 << cw[d]) - 1;
          c = m_ctr[d][res_idx] + (res_taken ? 1 : -1);
          if (c > cmax) c = cmax;
          if (c < 0) c = 0;
          m_ctr[d][res_idx] = c;
          m_ghr[d] = ((m_ghr[d] * 2) + int'(res_taken)) % (1 << hw[d]);
        end
        m_pv[d] = req_valid ? 1 : 0;
        if (req_valid) begin
          m_pt[d] = (m_ctr[d][idx] >= (1 << (cw[d] - 1))) ? 1 : 0;
          m_pi[d] = idx;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit qv, input int pc,
                      input bit sv, input int sidx, input bit st, input string tag);
    rst = r; req_valid = qv; req_pc = 4'(pc);
    res_valid = sv; res_idx = 4'(sidx); res_taken = st;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val({tag, "_a_valid"}, 32'(a_pv), 32'(m_pv[0]));
    check_val({tag, "_a_taken"}, 32'(a_pt), 32'(m_pt[0]));
    check_val({tag, "_a_idx"},   32'(a_pi), 32'(m_pi[0]));
    check_val({tag, "_b_valid"}, 32'(b_pv), 32'(m_pv[1]));
    check_val({tag, "_b_taken"}, 32'(b_pt), 32'(m_pt[1]));
    check_val({tag, "_b_idx"},   32'(b_pi), 32'(m_pi[1]));
  endtask

  task automatic train(input int idx, input bit tk, input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, idx, tk, tag);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_pc = '0;
    res_valid = 1'b0; res_idx = '0; res_taken = 1'b0;
    @(negedge clk);

    // Reset state and first lookup
    step(1, 0, 0, 0, 0, 0, "s1_rst");
    check_val("s1_rst_pv", 32'(a_pv), 0);
    step(0, 1, 3, 0, 0, 0, "s1_req");
    check_val("s1_pv", 32'(a_pv), 1);
    check_val("s1_idx", 32'(a_pi), 3);
    check_val("s1_taken", 32'(a_pt), 0);
    step(0, 0, 0, 0, 0, 0, "s1_idle");
    check_val("s1_pv_drop", 32'(a_pv), 0);
    check_val("s1_taken_hold", 32'(a_pt), 0);

    // Train entry 5, history becomes 0111
    train(5, 1, 3, "s2_train");
    step(0, 1, 2, 0, 0, 0, "s2_req");
    check_val("s2_idx", 32'(a_pi), 5);
    check_val("s2_taken", 32'(a_pt), 1);

    // Saturation both ways, with a forwarded same-cycle lookup
    train(5, 1, 5, "s3_sat_hi");
    step(0, 1, 5 ^ 15, 1, 5, 0, "s3_fwd");
    check_val("s3_fwd_idx", 32'(a_pi), 5);
    check_val("s3_fwd_taken", 32'(a_pt), 1);
    train(5, 0, 5, "s3_sat_lo");
    step(0, 1, 5, 0, 0, 0, "s3_req");
    check_val("s3_lo_taken", 32'(a_pt), 0);

    // Reset mid-stream ignores simultaneous request and result
    step(1, 0, 0, 0, 0, 0, "s5_rst0");
    train(5, 1, 3, "s5_train");
    step(1, 1, 2, 1, 5, 1, "s5_rst");
    check_val("s5_rst_pv", 32'(a_pv), 0);
    check_val("s5_rst_taken", 32'(a_pt), 0);
    step(0, 1, 5, 0, 0, 0, "s5_req");
    check_val("s5_idx", 32'(a_pi), 5);
    check_val("s5_taken", 32'(a_pt), 0);

    // Same-cycle collision between result and lookup
    step(1, 0, 0, 0, 0, 0, "s4_rst");
    step(0, 1, 4, 1, 4, 1, "s4_col");
    check_val("s4_idx", 32'(a_pi), 4);
    check_val("s4_taken", 32'(a_pt), 1);
    step(0, 1, 5, 0, 0, 0, "s4_req");
    check_val("s4_idx2", 32'(a_pi), 4);
    check_val("s4_taken2", 32'(a_pt), 1);

    // Wider counters, no history (second instance)
    step(1, 0, 0, 0, 0, 0, "s6_rst");
    step(0, 1, 7, 0, 0, 0, "s6_req0");
    check_val("s6_init_taken", 32'(b_pt), 0);
    step(0, 0, 0, 1, 7, 1, "s6_train");
    step(0, 1, 7, 0, 0, 0, "s6_req1");
    check_val("s6_idx", 32'(b_pi), 7);
    check_val("s6_taken", 32'(b_pt), 1);

    // Random traffic; result indices biased to a few entries to reach saturation
    for (int i = 0; i < 3000; i++) begin
      int sidx;
      sidx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 2) != 0), sidx, ($urandom_range(0, 9) < 7), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
